bsg_wormhole_concentrator_wrr: RTL and testbench

Bidirectional wormhole concentrator that merges `num_in_p` wormhole links onto one concentrated link and splits the return traffic back out by concentration id (cid). Sits between a group of endpoint nodes and a `bsg_wormhole_router` P port. It adds two capabilities over the basic concentrator:
- per-input weighted round-robin packet arbitration;
- safe discard, with counting, of return packets whose cid has no matching port.

---
 rtl/bsg_wormhole_concentrator_wrr.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bsg_wormhole_concentrator_wrr.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_concentrator_wrr.sv
// bsg_wormhole_concentrator_wrr
//   Merges num_in_p wormhole links onto one concentrated link using
//   per-input weighted round-robin packet arbitration, and splits return
//   traffic back out by cid. Return packets whose cid has no port are
//   discarded and counted.
//
// Ports
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   weights_i              per-input burst weight, input i at [i*W +: W]; 0 acts as 1
//   in_v_i/in_data_i/in_ready_o     unconcentrated inputs (ready&valid)
//   conc_v_o/conc_data_o/conc_ready_i  concentrated output
//   conc_v_i/conc_data_i/conc_ready_o  concentrated return input
//   out_v_o/out_data_o/out_ready_i     per-port return outputs
//   drop_count_o           saturating count of discarded return packets
//
// Header layout: cord [cord_width_p-1:0], then len, then cid.

module bsg_wormhole_concentrator_wrr_fifo2 #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               v_o,
  output logic               full_o,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (enq_i) wr_ptr_q <= ~wr_ptr_q;
      if (deq_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, enq_i} - {1'b0, deq_i};
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign v_o    = (count_q != 2'd0);
  assign full_o = (count_q == 2'd2);
  assign data_o = mem_q[rd_ptr_q];

endmodule

module bsg_wormhole_concentrator_wrr #(
  parameter int unsigned flit_width_p     = 32,
  parameter int unsigned cord_width_p     = 8,
  parameter int unsigned len_width_p      = 4,
  parameter int unsigned cid_width_p      = 2,
  parameter int unsigned num_in_p         = 3,
  parameter int unsigned weight_width_p   = 3,
  parameter int unsigned drop_ctr_width_p = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_in_p*weight_width_p-1:0]   weights_i,
  input  logic [num_in_p-1:0]                  in_v_i,
  input  logic [num_in_p*flit_width_p-1:0]     in_data_i,
  output logic [num_in_p-1:0]                  in_ready_o,
  output logic                                 conc_v_o,
  output logic [flit_width_p-1:0]              conc_data_o,
  input  logic                                 conc_ready_i,
  input  logic                                 conc_v_i,
  input  logic [flit_width_p-1:0]              conc_data_i,
  output logic                                 conc_ready_o,
  output logic [num_in_p-1:0]                  out_v_o,
  output logic [num_in_p*flit_width_p-1:0]     out_data_o,
  input  logic [num_in_p-1:0]                  out_ready_i,
  output logic [drop_ctr_width_p-1:0]          drop_count_o
);

  localparam int unsigned id_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int unsigned len_lsb_lp  = cord_width_p;
  localparam int unsigned cid_lsb_lp  = cord_width_p + len_width_p;

  // ---------------- concentrate path ----------------
  logic                      lock_v_q, lock_v_d;
  logic [id_width_lp-1:0]    lock_id_q, lock_id_d;
  logic [len_width_p-1:0]    flits_left_q, flits_left_d;
  logic [id_width_lp-1:0]    rr_ptr_q, rr_ptr_d;
  logic [weight_width_p-1:0] burst_cnt_q, burst_cnt_d;

  logic [weight_width_p-1:0] eff_w [num_in_p];
  logic [id_width_lp-1:0]    arb_id;
  logic                      arb_v;
  logic                      ofifo_full, in_xfer, in_accept_ok;
  logic [flit_width_p-1:0]   sel_data;
  logic [len_width_p-1:0]    sel_len;

  always_comb begin
    for (int unsigned i = 0; i < num_in_p; i++) begin
      eff_w[i] = weights_i[i*weight_width_p +: weight_width_p];
      if (eff_w[i] == '0) eff_w[i] = weight_width_p'(1);
    end
  end

  // Keep the last winner while its burst allowance lasts, otherwise scan
  // forward from rr_ptr+1; the scan ends on rr_ptr itself so a lone
  // requester is never starved.
  always_comb begin
    int unsigned idx;
    arb_id = rr_ptr_q;
    arb_v  = 1'b0;
    idx    = 0;
    if (in_v_i[rr_ptr_q] && (burst_cnt_q < eff_w[rr_ptr_q])) begin
      arb_v = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= num_in_p; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= num_in_p) idx = idx - num_in_p;
        if (!arb_v && in_v_i[idx]) begin
          arb_v  = 1'b1;
          arb_id = id_width_lp'(idx);
        end
      end
    end
  end

  assign in_accept_ok = reset_n_i && !ofifo_full;

  always_comb begin
    in_ready_o = '0;
    sel_data   = '0;
    in_xfer    = 1'b0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      if (lock_v_q ? (lock_id_q == id_width_lp'(i))
                   : (arb_v && (arb_id == id_width_lp'(i)))) begin
        in_ready_o[i] = in_accept_ok;
        sel_data      = in_data_i[i*flit_width_p +: flit_width_p];
        in_xfer       = in_accept_ok && in_v_i[i];
      end
    end
  end

  assign sel_len = sel_data[len_lsb_lp +: len_width_p];

  always_comb begin
    lock_v_d     = lock_v_q;
    lock_id_d    = lock_id_q;
    flits_left_d = flits_left_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    if (in_xfer) begin
      if (!lock_v_q) begin
        lock_id_d    = arb_id;
        flits_left_d = sel_len;
        lock_v_d     = (sel_len != '0);
        if (arb_id == rr_ptr_q) begin
          if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          rr_ptr_d    = arb_id;
          burst_cnt_d = weight_width_p'(1);
        end
      end else begin
        flits_left_d = flits_left_q - 1'b1;
        if (flits_left_q == len_width_p'(1)) lock_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_v_q     <= 1'b0;
      lock_id_q    <= '0;
      flits_left_q <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
    end else begin
      lock_v_q     <= lock_v_d;
      lock_id_q    <= lock_id_d;
      flits_left_q <= flits_left_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  bsg_wormhole_concentrator_wrr_fifo2 #(.width_p(flit_width_p)) ofifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .enq_i    (in_xfer),
    .data_i   (sel_data),
    .deq_i    (conc_v_o && conc_ready_i),
    .v_o      (conc_v_o),
    .full_o   (ofifo_full),
    .data_o   (conc_data_o)
  );

  // ---------------- deconcentrate path ----------------
  typedef enum logic [1:0] {R_HDR, R_ROUTE, R_DROP} rstate_e;

  rstate_e                     rstate_q, rstate_d;
  logic [cid_width_p-1:0]      rid_q, rid_d;
  logic [len_width_p-1:0]      rleft_q, rleft_d;
  logic [drop_ctr_width_p-1:0] drop_q, drop_d;

  logic                        rfifo_v, rfifo_full, rdeq;
  logic [flit_width_p-1:0]     rfifo_data;
  logic [len_width_p-1:0]      h_len;
  logic [cid_width_p-1:0]      h_cid, port;
  logic                        cid_ok, routed, port_ready;

  assign conc_ready_o = reset_n_i && !rfifo_full;
  assign h_len        = rfifo_data[len_lsb_lp +: len_width_p];
  assign h_cid        = rfifo_data[cid_lsb_lp +: cid_width_p];
  assign cid_ok       = (32'(h_cid) < num_in_p);
  assign out_data_o   = {num_in_p{rfifo_data}};
  assign drop_count_o = drop_q;

  always_comb begin
    rstate_d   = rstate_q;
    rid_d      = rid_q;
    rleft_d    = rleft_q;
    drop_d     = drop_q;
    out_v_o    = '0;
    port_ready = 1'b0;
    port       = (rstate_q == R_HDR) ? h_cid : rid_q;
    routed     = (rstate_q == R_ROUTE) || ((rstate_q == R_HDR) && cid_ok);
    for (int unsigned i = 0; i < num_in_p; i++) begin
      if (32'(port) == i) begin
        port_ready = out_ready_i[i];
        out_v_o[i] = rfifo_v && routed;
      end
    end
    // Unroutable flits leave the FIFO without waiting on any port.
    rdeq = rfifo_v && (routed ? port_ready : 1'b1);
    if (rdeq) begin
      case (rstate_q)
        R_HDR: begin
          rid_d   = h_cid;
          rleft_d = h_len;
          if (h_len != '0) rstate_d = cid_ok ? R_ROUTE : R_DROP;
          if (!cid_ok && (drop_q != '1)) drop_d = drop_q + 1'b1;
        end
        default: begin
          rleft_d = rleft_q - 1'b1;
          if (rleft_q == len_width_p'(1)) rstate_d = R_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rstate_q <= R_HDR;
      rid_q    <= '0;
      rleft_q  <= '0;
      drop_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      rleft_q  <= rleft_d;
      drop_q   <= drop_d;
    end
  end

  bsg_wormhole_concentrator_wrr_fifo2 #(.width_p(flit_width_p)) rfifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .enq_i    (conc_v_i && conc_ready_o),
    .data_i   (conc_data_i),
    .deq_i    (rdeq),
    .v_o      (rfifo_v),
    .full_o   (rfifo_full),
    .data_o   (rfifo_data)
  );

endmodule

// File: tb/tb_bsg_wormhole_concentrator_wrr.sv
module tb_bsg_wormhole_concentrator_wrr;

  localparam int FW = 32;
  localparam int N  = 3;
  localparam int WW = 3;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N*WW-1:0] weights_i;
  logic [N-1:0]    in_v_i;
  logic [N*FW-1:0] in_data_i;
  logic [N-1:0]    in_ready_o;
  logic            conc_v_o;
  logic [FW-1:0]   conc_data_o;
  logic            conc_ready_i;
  logic            conc_v_i;
  logic [FW-1:0]   conc_data_i;
  logic            conc_ready_o;
  logic [N-1:0]    out_v_o;
  logic [N*FW-1:0] out_data_o;
  logic [N-1:0]    out_ready_i;
  logic [15:0]     drop_count_o;

  always #5 clk_i = ~clk_i;

  bsg_wormhole_concentrator_wrr #(
    .flit_width_p(FW), .cord_width_p(8), .len_width_p(4), .cid_width_p(2),
    .num_in_p(N), .weight_width_p(WW), .drop_ctr_width_p(16)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .weights_i(weights_i),
    .in_v_i(in_v_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .conc_v_o(conc_v_o), .conc_data_o(conc_data_o), .conc_ready_i(conc_ready_i),
    .conc_v_i(conc_v_i), .conc_data_i(conc_data_i), .conc_ready_o(conc_ready_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .drop_count_o(drop_count_o)
  );

  typedef struct { logic [FW-1:0] d; bit h; } flit_t;
  typedef struct { logic [N*WW-1:0] w; int len; int warm; int nexp; int exp_g[10]; } arb_vec_t;

  flit_t         srcq   [N][$];
  logic [FW-1:0] retexp [N][$];
  logic [FW-1:0] expq[$], retq[$], olog[$], plan[$];
  int            ocyc[$], grants[$];
  int            rx [N];
  logic [N-1:0]  en;
  int checks = 0, failures = 0, cyc_n = 0, hdr_acc_cyc = 0;
  arb_vec_t vecs [3];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected-transfer expected=none", name);
  endtask

  function automatic logic [FW-1:0] hdr(int tag, int cid, int len);
    return {18'(tag), 2'(cid), 4'(len), 8'h5A};
  endfunction

  function automatic logic [FW-1:0] pay(int tag, int k);
    return {16'(tag), 8'hC3, 8'(k)};
  endfunction

  task automatic add_pkt(int i, int tag, int len);
    flit_t f;
    f.d = hdr(tag, 0, len); f.h = 1'b1;
    srcq[i].push_back(f); plan.push_back(f.d);
    for (int k = 1; k <= len; k++) begin
      f.d = pay(tag, k); f.h = 1'b0;
      srcq[i].push_back(f); plan.push_back(f.d);
    end
  endtask

  task automatic add_ret(int tag, int cid, int len);
    logic [FW-1:0] w;
    for (int k = 0; k <= len; k++) begin
      w = (k == 0) ? hdr(tag, cid, len) : pay(tag, k);
      retq.push_back(w);
      if (cid < N) retexp[cid].push_back(w);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete(); retexp[i].delete(); rx[i] = 0;
    end
    expq.delete(); retq.delete(); olog.delete(); ocyc.delete();
    plan.delete(); grants.delete();
  endtask

  function automatic bit idle_all();
    bit r = (expq.size() == 0) && (retq.size() == 0);
    for (int i = 0; i < N; i++)
      if (srcq[i].size() != 0 || retexp[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, observe handshakes at negedge.
  task automatic cyc();
    flit_t f;
    logic [FW-1:0] w;
    for (int i = 0; i < N; i++) begin
      in_v_i[i] = en[i] && (srcq[i].size() != 0);
      in_data_i[i*FW +: FW] = (srcq[i].size() != 0) ? srcq[i][0].d : '0;
    end
    conc_v_i    = (retq.size() != 0);
    conc_data_i = (retq.size() != 0) ? retq[0] : '0;
    @(negedge clk_i);
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (in_v_i[i] && in_ready_o[i]) begin
        f = srcq[i].pop_front();
        expq.push_back(f.d);
        if (f.h) begin grants.push_back(i); hdr_acc_cyc = cyc_n; end
      end
    end
    if (conc_v_o && conc_ready_i) begin
      if (expq.size() == 0) flag("conc_extra");
      else begin w = expq.pop_front(); chk("conc_data", conc_data_o, w); end
      olog.push_back(conc_data_o);
      ocyc.push_back(cyc_n);
    end
    if (conc_v_i && conc_ready_o) void'(retq.pop_front());
    for (int p = 0; p < N; p++) begin
      if (out_v_o[p] && out_ready_i[p]) begin
        if (retexp[p].size() == 0) flag($sformatf("ret_stray_p%0d", p));
        else begin
          w = retexp[p].pop_front();
          chk($sformatf("ret_data_p%0d", p), out_data_o[p*FW +: FW], w);
        end
        rx[p]++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(int bound, string name);
    int k = 0;
    while (!idle_all() && k < bound) begin cyc(); k++; end
    chk(name, 32'(idle_all()), 32'd1);
  endtask

  task automatic do_reset();
    in_v_i = '0; conc_v_i = 1'b0; reset_n_i = 1'b0;
    clear_all();
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
  endtask

  initial begin
    int k;
    vecs[0].w = {3'd1, 3'd1, 3'd1}; vecs[0].len = 2; vecs[0].warm = 1; vecs[0].nexp = 9;
    vecs[0].exp_g = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 0};
    vecs[1].w = {3'd0, 3'd1, 3'd3}; vecs[1].len = 0; vecs[1].warm = 3; vecs[1].nexp = 10;
    vecs[1].exp_g = '{1, 2, 0, 0, 0, 1, 2, 0, 0, 0};
    vecs[2].w = {3'd2, 3'd2, 3'd2}; vecs[2].len = 1; vecs[2].warm = 0; vecs[2].nexp = 9;
    vecs[2].exp_g = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 0};

    weights_i = {3'd1, 3'd1, 3'd1};
    out_ready_i = '1; conc_ready_i = 1'b1; en = '1;
    in_data_i = '0; conc_data_i = '0;
    reset_n_i = 1'b0; in_v_i = '1; conc_v_i = 1'b1;
    #12;
    chk("rst_conc_v", 32'(conc_v_o), 0);
    chk("rst_out_v", 32'(out_v_o), 0);
    chk("rst_in_ready", 32'(in_ready_o), 0);
    chk("rst_conc_ready", 32'(conc_ready_o), 0);
    chk("rst_drop", 32'(drop_count_o), 0);
    in_v_i = '0; conc_v_i = 1'b0;
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    #1 chk("rdy_after_rst", 32'(conc_ready_o), 1);

    // Weighted round-robin vectors
    for (int v = 0; v < 3; v++) begin
      weights_i = vecs[v].w;
      do_reset();
      en = 3'b001;
      for (int p = 0; p < vecs[v].warm; p++) add_pkt(0, 900 + p, 0);
      drain(50, $sformatf("v%0d_warm_drain", v));
      grants.delete(); olog.delete(); ocyc.delete();
      en = '1;
      for (int p = 0; p < 8; p++)
        for (int i = 0; i < N; i++) add_pkt(i, v*100 + i*10 + p, vecs[v].len);
      drain(400, $sformatf("v%0d_drain", v));
      for (int g = 0; g < vecs[v].nexp; g++)
        chk($sformatf("v%0d_grant%0d", v, g), (grants.size() > g) ? grants[g] : -1, vecs[v].exp_g[g]);
      chk($sformatf("v%0d_flits", v), olog.size(), 24 * (vecs[v].len + 1));
      if (ocyc.size() > 0)
        chk($sformatf("v%0d_no_idle", v), ocyc[ocyc.size()-1] - ocyc[0] + 1, ocyc.size());
    end

    // Locked packet is not preempted by a later header
    weights_i = {3'd1, 3'd1, 3'd1};
    do_reset();
    en = '1;
    add_pkt(0, 500, 5);
    k = 0;
    while (srcq[0].size() > 4 && k < 20) begin cyc(); k++; end
    add_pkt(1, 510, 0);
    drain(40, "np_drain");
    chk("np_count", olog.size(), 7);
    for (int j = 0; j < 7; j++)
      if (j < olog.size() && j < plan.size()) chk($sformatf("np_order%0d", j), olog[j], plan[j]);
    if (ocyc.size() == 7) chk("np_contig", ocyc[6] - ocyc[0], 6);

    // Return packet with unmatched cid is dropped and counted
    do_reset();
    add_ret(600, 3, 4);
    add_ret(610, 1, 1);
    drain(40, "drop_drain");
    repeat (2) cyc();
    chk("drop_count", 32'(drop_count_o), 1);
    chk("drop_rx1", rx[1], 2);
    chk("drop_rx_other", rx[0] + rx[2], 0);

    // Return backpressure fills the 2-entry FIFO
    do_reset();
    out_ready_i = 3'b011;
    add_ret(700, 2, 3);
    repeat (6) cyc();
    chk("bp_accepted", retq.size(), 2);
    chk("bp_conc_ready", 32'(conc_ready_o), 0);
    chk("bp_out_v", 32'(out_v_o), 32'b100);
    out_ready_i = '1;
    drain(30, "bp_drain");
    chk("bp_rx2", rx[2], 4);

    // Reset pulse in the middle of the third output flit
    do_reset();
    add_pkt(0, 800, 4);
    add_ret(810, 0, 4);
    k = 0;
    while (olog.size() < 2 && k < 20) begin cyc(); k++; end
    chk("mr_pre_v", 32'(conc_v_o), 1);
    #2;
    in_v_i = '0; conc_v_i = 1'b0; reset_n_i = 1'b0;
    #1;
    chk("mr_conc_v", 32'(conc_v_o), 0);
    chk("mr_out_v", 32'(out_v_o), 0);
    chk("mr_in_ready", 32'(in_ready_o), 0);
    chk("mr_conc_ready", 32'(conc_ready_o), 0);
    chk("mr_drop", 32'(drop_count_o), 0);
    reset_n_i = 1'b1;
    clear_all();
    @(posedge clk_i);
    #1;
    chk("mr_after_v", 32'(conc_v_o), 0);
    chk("mr_after_ready", 32'(conc_ready_o), 1);
    add_pkt(0, 820, 2);
    drain(20, "mr_drain");
    chk("mr_count", olog.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < olog.size() && j < plan.size()) chk($sformatf("mr_order%0d", j), olog[j], plan[j]);
    if (ocyc.size() > 0) chk("mr_latency", ocyc[0], hdr_acc_cyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
